rvmyth_dac_sample_pacer: RTL
============================

Name: rvmyth_dac_sample_pacer

Overview:
- Buffering and pacing stage between the RVMYTH core's 10-bit output and the avsddac input.
- Accepts samples from the core in bursts through a valid/ready handshake and stores them in a small FIFO.
- Presents them to the DAC at a fixed, programmable sample rate.
- Guarantees a stable DAC code between updates, a defined midscale idle level, and an underflow indication when the core falls behind.

Parameters:
- DATA_W, 10, sample width; matches the DAC code width.
- DEPTH, 8, FIFO depth in samples; power of 2, minimum 2.
- DIV_W, 16, width of the sample-period divisor.
- DEFAULT_DIV, 4, sample period in clk cycles after reset.
- PRIME_LVL, 4, FIFO level required before playback starts; 1..DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  input  DATA_W  sample from core.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full.
- div_load  input  1  load div_value into the divisor register.
- div_value  input  DIV_W  new sample period in cycles.
- dac_d  output  DATA_W  registered code to DAC.
- dac_strobe  output  1  one-cycle pulse when dac_d takes a new sample.
- underflow  output  1  one-cycle pulse on a tick with an empty FIFO in RUN.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied, level=0, in_ready=1.
  - Divisor=DEFAULT_DIV, period counter=0.
  - state=IDLE, dac_d=midscale (1<<(DATA_W-1), 0x200), dac_strobe=0, underflow=0.
  - Reset may assert at any cycle. All state clears immediately and no partial sample is emitted.
- Push:
  - A push occurs when in_valid && in_ready at a clk edge.
  - When full, in_ready=0 and in_valid is ignored; no overwrite.
- Tick generation:
  - The period counter counts 0..P-1, where P=max(divisor,1). tick=1 when counter==P-1.
  - Divisor 0 behaves as 1, giving a tick every cycle.
  - div_load: the divisor takes div_value at the edge and the counter resets to 0. The first tick at the new rate is P cycles later.
  - The counter runs in all states.
- State machine:
  - IDLE: dac_d held at midscale. Moves to PRIME on the first accepted push.
  - PRIME: dac_d held. On a tick with level>=PRIME_LVL, moves to RUN and performs the first pop on that same tick.
  - RUN: on each tick:
    - If level>0: pop the head, so dac_d<=head and dac_strobe=1 in the following cycle.
    - If level==0: dac_d holds its last value, underflow=1 for one cycle, and the state stays RUN.
  - RUN to IDLE: after 4 consecutive underflow ticks, dac_d returns to midscale one cycle after the 4th underflow pulse.
- Latency:
  - Pop at tick edge; dac_d and dac_strobe are visible in the next cycle.
  - Minimum push-to-dac_d latency is 1 cycle when the FIFO is already primed and a tick coincides.
- Simultaneous events:
  - Push and pop in the same cycle leave level unchanged, and data order is preserved.
  - No fall-through: a push into an empty FIFO in the same cycle as a tick does not satisfy that tick (an underflow occurs if in RUN).
  - div_load coinciding with a tick: the tick is honoured, then the counter restarts.
- Arithmetic:
  - FIFO pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is computed from pointers carrying an extra MSB, so full is level==DEPTH and empty is level==0.
- Outputs: all outputs are registered except in_ready.

Optional Feature:
- Macro: DAC_PACER_STATS_EN.
- Defined:
  - Adds output port underflow_cnt [15:0].
  - Increments on every underflow pulse and saturates at 0xFFFF.
  - Cleared only by reset.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Reset check: release reset with divisor 4 and no pushes → dac_d=0x200, dac_strobe and underflow never pulse, in_ready=1 for 50 cycles.
- Prime and playback: push 0x001..0x006 back-to-back, divisor 4.
  - dac_d steps 0x001..0x006 on successive ticks, 4 cycles apart.
  - No dac_strobe before level has reached 4 at a tick.
- Full and backpressure: divisor 100, push 10 samples continuously.
  - in_ready drops after 8 accepted and level=8.
  - Samples 9 and 10 are not accepted until a pop frees space.
  - Played order matches accepted order.
- Underflow and fallback: 4 samples played, then no pushes.
  - 4 underflow pulses one period apart, dac_d holds the last value.
  - dac_d returns to 0x200 after the 4th underflow pulse.
  - With DAC_PACER_STATS_EN, underflow_cnt=4.
- Rate change: playing at divisor 4, assert div_load with div_value=0.
  - From the next cycle, ticks occur every cycle and dac_strobe pulses each cycle while level>0.
- Reset mid-run: assert reset low for 1 cycle during RUN with level=5.
  - Immediately level=0, dac_d=0x200, state IDLE.
  - After release, a fresh 4-sample prime is required before the next dac_strobe.

Source files
------------

// File: rtl/rvmyth_dac_sample_pacer.sv
// Paced FIFO between the RVMYTH 10-bit output and the avsddac input: bursty writes in, one code per period out.
// Optional DAC_PACER_STATS_EN adds a saturating underflow_cnt output.
module rvmyth_dac_sample_pacer #(
    parameter int DATA_W      = 10,
    parameter int DEPTH       = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int PRIME_LVL   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     div_load,
    input  logic [DIV_W-1:0]         div_value,
    output logic [DATA_W-1:0]        dac_d,
    output logic                     dac_strobe,
    output logic                     underflow,
`ifdef DAC_PACER_STATS_EN
    output logic [15:0]              underflow_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     lvl;
    logic              push, pop, tick;
    logic [DIV_W-1:0]  div_q, cnt_q, cnt_d, period;
    state_e            state_q, state_d;
    logic [1:0]        uf_run_q, uf_run_d;
    logic [DATA_W-1:0] code_q, code_d;
    logic              strobe_q, strobe_d, uf_q, uf_d;

    assign lvl      = wr_ptr_q - rd_ptr_q;
    assign in_ready = (lvl != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign period   = (div_q == '0) ? DIV_W'(1) : div_q;
    assign tick     = (cnt_q == period - DIV_W'(1));

    // A load restarts the period; a coinciding tick has already been acted on this edge.
    assign cnt_d = (div_load || tick) ? '0 : cnt_q + DIV_W'(1);

    always_comb begin
        state_d  = state_q;
        uf_run_d = uf_run_q;
        pop      = 1'b0;
        uf_d     = 1'b0;
        strobe_d = 1'b0;
        code_d   = code_q;
        case (state_q)
            IDLE: begin
                code_d = MID;
                if (push || lvl != '0) state_d = PRIME;
            end
            PRIME: begin
                if (tick && lvl >= LW'(PRIME_LVL)) begin
                    pop      = 1'b1;
                    state_d  = RUN;
                    uf_run_d = '0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (lvl != '0) begin
                        pop      = 1'b1;
                        uf_run_d = '0;
                    end else begin
                        uf_d = 1'b1;
                        if (uf_run_q == 2'd3) begin
                            state_d  = IDLE;
                            uf_run_d = '0;
                        end else begin
                            uf_run_d = uf_run_q + 2'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Occupancy is sampled before this edge's push, so an empty FIFO never falls through.
        if (pop) begin
            code_d   = mem[rd_ptr_q[AW-1:0]];
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            cnt_q    <= '0;
            state_q  <= IDLE;
            uf_run_q <= '0;
            code_q   <= MID;
            strobe_q <= 1'b0;
            uf_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (div_load) div_q <= div_value;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            uf_run_q <= uf_run_d;
            code_q   <= code_d;
            strobe_q <= strobe_d;
            uf_q     <= uf_d;
        end
    end

`ifdef DAC_PACER_STATS_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         ucnt_q <= '0;
        else if (uf_d && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end
    assign underflow_cnt = ucnt_q;
`endif

    assign dac_d      = code_q;
    assign dac_strobe = strobe_q;
    assign underflow  = uf_q;
    assign level      = lvl;
endmodule
